// File: rtl/gpr_wb_queue.sv
// gpr_wb_queue: buffers register writebacks from the WB stage and drains them
// into the register file write port at one per cycle, in acceptance order.
// Source-operand lookups (rs/rt) report whether a pending write targets the
// index and, when forwarding is built in, the value of the youngest match.
// Optional feature: define GPR_WB_FWD_EN to build the rs_fwd/rt_fwd data
// select; otherwise rs_fwd/rt_fwd are tied to 0 and only hits are produced.
module gpr_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        wb_hold,
    output logic        gpr_w_en,
    output logic [4:0]  gpr_w_addr,
    output logic [31:0] gpr_w_data,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        rs_hit,
    output logic        rt_hit,
    output logic [31:0] rs_fwd,
    output logic [31:0] rt_fwd,
    output logic        empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    addr_q [DEPTH];
    logic [4:0]    addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;

    logic push;
    logic pop;
    logic [DEPTH-1:0] rs_match;
    logic [DEPTH-1:0] rt_match;

    // Handshake and drain strobes. A write to $0 completes the handshake but
    // is never stored since the register is hardwired.
    assign wr_ready = rst_n && (count_q != FULL_COUNT);
    assign empty    = (count_q == '0);
    assign push     = wr_valid && wr_ready && (wr_addr != 5'd0);
    assign pop      = rst_n && !empty && !wb_hold;

    // Register-file port driven from the head entry; zero when not writing.
    always_comb begin
        gpr_w_en   = pop;
        gpr_w_addr = 5'd0;
        gpr_w_data = 32'd0;
        if (pop) begin
            gpr_w_addr = addr_q[rd_ptr_q];
            gpr_w_data = data_q[rd_ptr_q];
        end
    end

    // Per-entry match against both source indices; index 0 never matches.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign rs_match[gi] = valid_q[gi] && (rs_addr != 5'd0) && (addr_q[gi] == rs_addr);
            assign rt_match[gi] = valid_q[gi] && (rt_addr != 5'd0) && (addr_q[gi] == rt_addr);
        end
    endgenerate

    assign rs_hit = rst_n && (|rs_match);
    assign rt_hit = rst_n && (|rt_match);

`ifdef GPR_WB_FWD_EN
    logic [PW-1:0] age_idx [DEPTH];

    // age_idx[k] is the slot holding the k-th oldest entry (0 = head).
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            assign age_idx[gi] = rd_ptr_q + PW'(gi);
        end
    endgenerate

    // Walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        rs_fwd = 32'd0;
        rt_fwd = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (rs_match[age_idx[k]]) begin
                rs_fwd = data_q[age_idx[k]];
            end
            if (rt_match[age_idx[k]]) begin
                rt_fwd = data_q[age_idx[k]];
            end
        end
        if (!rst_n) begin
            rs_fwd = 32'd0;
            rt_fwd = 32'd0;
        end
    end
`else
    assign rs_fwd = 32'd0;
    assign rt_fwd = 32'd0;
`endif

    // Next-state for pointers, occupancy and entry storage.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = wr_addr;
            data_d[wr_ptr_q]  = wr_data;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every pending entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 5'd0;
                data_q[i] <= 32'd0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_gpr_wb_queue.sv
// Directed testbench for gpr_wb_queue (DEPTH = 4). Register-file writes are
// logged from the write port and compared against the expected write order.
module tb_gpr_wb_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wb_hold;
    logic        gpr_w_en;
    logic [4:0]  gpr_w_addr;
    logic [31:0] gpr_w_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_hit;
    logic        rt_hit;
    logic [31:0] rs_fwd;
    logic [31:0] rt_fwd;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0]  log_a [$];
    logic [31:0] log_d [$];
    logic [4:0]  exp_a [$];
    logic [31:0] exp_d [$];

`ifdef GPR_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    always #5 clk = ~clk;

    gpr_wb_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wb_hold    (wb_hold),
        .gpr_w_en   (gpr_w_en),
        .gpr_w_addr (gpr_w_addr),
        .gpr_w_data (gpr_w_data),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_hit     (rs_hit),
        .rt_hit     (rt_hit),
        .rs_fwd     (rs_fwd),
        .rt_fwd     (rt_fwd),
        .empty      (empty)
    );

    // Register-file model: a strobe seen mid-cycle is written at the next edge.
    always @(negedge clk) begin
        if (gpr_w_en === 1'b1) begin
            log_a.push_back(gpr_w_addr);
            log_d.push_back(gpr_w_data);
            $display("RF write addr=%0d data=0x%08h", gpr_w_addr, gpr_w_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare logged register-file writes against the expected order, then clear.
    task automatic check_log(input string tag);
        check({tag, "_count"}, log_a.size(), exp_a.size());
        while (log_a.size() > 0 && exp_a.size() > 0) begin
            check({tag, "_addr"}, {27'd0, log_a.pop_front()}, {27'd0, exp_a.pop_front()});
            check({tag, "_data"}, log_d.pop_front(), exp_d.pop_front());
        end
        log_a.delete(); log_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        wb_hold = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0;

        // Reset state
        tick(); tick();
        rs_addr = 5'd5; rt_addr = 5'd5;
        #1;
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("rst_gpr_w_en", {31'd0, gpr_w_en}, 32'd0);
        check("rst_gpr_w_addr", {27'd0, gpr_w_addr}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_rs_hit", {31'd0, rs_hit}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single write, one-cycle latency
        wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'h11111111;
        #1;
        check("single_ready", {31'd0, wr_ready}, 32'd1);
        tick();
        wr_valid = 1'b0;
        #1;
        check("single_w_en", {31'd0, gpr_w_en}, 32'd1);
        check("single_w_addr", {27'd0, gpr_w_addr}, 32'd5);
        check("single_w_data", gpr_w_data, 32'h11111111);
        check("single_rs_hit", {31'd0, rs_hit}, 32'd1);
        check("single_rs_fwd", rs_fwd, FWD ? 32'h11111111 : 32'd0);
        expect_write(5'd5, 32'h11111111);
        tick();
        check("single_empty", {31'd0, empty}, 32'd1);
        check("single_w_en_off", {31'd0, gpr_w_en}, 32'd0);
        check_log("single_log");

        // Fill under hold; 5th offer refused; drain in order
        wb_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(i + 1); wr_data = 32'hA0 + 32'(i);
            #1;
            check("fill_ready", {31'd0, wr_ready}, (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) expect_write(5'(i + 1), 32'hA0 + 32'(i));
            tick();
        end
        wr_valid = 1'b0;
        #1;
        check("full_w_en_held", {31'd0, gpr_w_en}, 32'd0);
        wb_hold = 1'b0;
        #1;
        check("full_ready_pre", {31'd0, wr_ready}, 32'd0);
        check("drain0_addr", {27'd0, gpr_w_addr}, 32'd1);
        check("drain0_data", gpr_w_data, 32'hA0);
        tick();
        check("full_ready_post", {31'd0, wr_ready}, 32'd1);
        check("drain1_addr", {27'd0, gpr_w_addr}, 32'd2);
        tick(); tick(); tick();
        check("drained_empty", {31'd0, empty}, 32'd1);
        check_log("fill_log");

        // Youngest-match forwarding
        wb_hold = 1'b1;
        wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'hA;
        tick();
        wr_data = 32'hB;
        tick();
        wr_valid = 1'b0; rs_addr = 5'd7; rt_addr = 5'd8;
        #1;
        check("fwd_rs_hit", {31'd0, rs_hit}, 32'd1);
        check("fwd_rs_fwd", rs_fwd, FWD ? 32'hB : 32'd0);
        check("fwd_rt_miss", {31'd0, rt_hit}, 32'd0);
        check("fwd_rt_fwd0", rt_fwd, 32'd0);
        rt_addr = 5'd7;
        #1;
        check("fwd_rt_hit", {31'd0, rt_hit}, 32'd1);
        check("fwd_rt_fwd", rt_fwd, FWD ? 32'hB : 32'd0);
        expect_write(5'd7, 32'hA);
        expect_write(5'd7, 32'hB);
        wb_hold = 1'b0;
        tick();
        check("fwd_one_left_hit", {31'd0, rs_hit}, 32'd1);
        check("fwd_one_left_fwd", rs_fwd, FWD ? 32'hB : 32'd0);
        tick();
        check("fwd_after_hit", {31'd0, rs_hit}, 32'd0);
        check_log("fwd_log");

        // Write to $0: handshake only
        wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF; rt_addr = 5'd0;
        #1;
        check("zero_ready", {31'd0, wr_ready}, 32'd1);
        tick();
        wr_valid = 1'b0;
        #1;
        check("zero_empty", {31'd0, empty}, 32'd1);
        check("zero_w_en", {31'd0, gpr_w_en}, 32'd0);
        check("zero_rt_hit", {31'd0, rt_hit}, 32'd0);
        tick();
        check_log("zero_log");

        // Reset discards pending writes
        wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(10 + i); wr_data = 32'hC0 + 32'(i);
            tick();
        end
        wr_valid = 1'b0;
        #1;
        check("prerst_empty", {31'd0, empty}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; wb_hold = 1'b0; rs_addr = 5'd10;
        #1;
        check("postrst_empty", {31'd0, empty}, 32'd1);
        check("postrst_w_en", {31'd0, gpr_w_en}, 32'd0);
        check("postrst_rs_hit", {31'd0, rs_hit}, 32'd0);
        tick(); tick(); tick();
        check_log("rst_log");

        // Steady stream: accept and drain every cycle
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'b1; wr_addr = 5'((i % 31) + 1); wr_data = 32'h1000 + 32'(i);
            expect_write(5'((i % 31) + 1), 32'h1000 + 32'(i));
            #1;
            check("stream_ready", {31'd0, wr_ready}, 32'd1);
            if (i > 0) begin
                check("stream_not_empty", {31'd0, empty}, 32'd0);
                check("stream_head", {27'd0, gpr_w_addr}, 32'(((i - 1) % 31) + 1));
            end
            tick();
        end
        wr_valid = 1'b0;
        #1;
        check("stream_last", gpr_w_data, 32'h1000 + 32'd19);
        tick();
        check("stream_empty", {31'd0, empty}, 32'd1);
        check_log("stream_log");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
